// File: rtl/rll_key_loader.sv
// rll_key_loader
// Serial key-delivery stage in front of the locked combinational core.
// A frame of KEY_W data bits (LSB first) plus one even-parity bit is shifted
// into a shadow register. Only a parity-verified key is ever placed on
// key_out; at all other times the core sees DECOY_KEY.
//
// Handshake: a bit is transferred on a rising edge where nvm_valid && nvm_ready.
// nvm_ready is a registered output, high only while the FSM is in SHIFT, and it
// drops on the same edge that accepts the parity bit, so no extra bit is taken.
//
// All outputs are registered; there is no combinational input->output path.
module rll_key_loader #(
    parameter int               KEY_W     = 16,
    parameter logic [KEY_W-1:0] DECOY_KEY = KEY_W'(16'hA5C3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             nvm_valid,
    input  logic             nvm_bit,
    output logic             nvm_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             key_err,
    output logic             busy,
    output logic [2:0]       dbg_state_o
);

    // Counter must reach KEY_W (the index of the parity bit).
    localparam int               CNT_W    = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic               par_q,    par_d;
    logic [KEY_W-1:0]   key_q,    key_d;
    logic               valid_q,  valid_d;
    logic               err_q,    err_d;
    logic               ready_q,  ready_d;
    logic               busy_q,   busy_d;

    logic               accept;

    // ready_q is only ever set while in SHIFT, so this is the full transfer
    // condition.
    assign accept = nvm_valid && ready_q;

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        par_d    = par_q;
        key_d    = key_q;
        valid_d  = valid_q;
        err_d    = err_q;
        ready_d  = ready_q;
        busy_d   = busy_q;

        case (state_q)
            // Idle or holding a result: a start request clears any committed
            // key and error, hides the old key behind the decoy, and opens
            // the serial port on the very same edge.
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_start) begin
                    state_d  = ST_SHIFT;
                    cnt_d    = '0;
                    shadow_d = '0;
                    par_d    = 1'b0;
                    key_d    = DECOY_KEY;
                    valid_d  = 1'b0;
                    err_d    = 1'b0;
                    ready_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end

            // Collect data bits into the shadow register; the bit taken
            // when the count equals KEY_W is the parity bit. load_start is
            // deliberately ignored here.
            ST_SHIFT: begin
                if (accept) begin
                    par_d = par_q ^ nvm_bit;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_CHECK;
                        ready_d = 1'b0;
                    end else begin
                        for (int i = 0; i < KEY_W; i++) begin
                            if (cnt_q == CNT_W'(i)) begin
                                shadow_d[i] = nvm_bit;
                            end
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            // One-cycle verdict: an even total of ones commits the shadow
            // key, anything else keeps the decoy and flags an error.
            ST_CHECK: begin
                ready_d = 1'b0;
                busy_d  = 1'b0;
                if (!par_q) begin
                    key_d   = shadow_q;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    key_d   = DECOY_KEY;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                shadow_d = '0;
                par_d    = 1'b0;
                key_d    = DECOY_KEY;
                valid_d  = 1'b0;
                err_d    = 1'b0;
                ready_d  = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            par_q    <= 1'b0;
            key_q    <= DECOY_KEY;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            par_q    <= par_d;
            key_q    <= key_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign nvm_ready   = ready_q;
    assign key_out     = key_q;
    assign key_valid   = valid_q;
    assign key_err     = err_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Testbench for rll_key_loader: reset checks, a table of directed frames,
// hand-written multi-cycle corner cases and randomized frames checked
// against a parity model.
module tb_rll_key_loader;

    localparam logic [15:0] DECOY = 16'hA5C3;
    localparam logic [2:0]  IDLE_ENC = 3'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        nvm_valid;
    logic        nvm_bit;
    logic        nvm_ready;
    logic [15:0] key_out;
    logic        key_valid;
    logic        key_err;
    logic        busy;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] key;
        logic        pbit;
        int          stall;   // 0 none, 1 toggle, 2 random
        bit          poke;    // pulse load_start during SHIFT
        logic [15:0] exp_out;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    rll_key_loader dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .nvm_valid   (nvm_valid),
        .nvm_bit     (nvm_bit),
        .nvm_ready   (nvm_ready),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .key_err     (key_err),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reset for two cycles; optional noise on the inputs checks reset priority.
    task automatic do_reset(input bit noise);
        rst        = 1'b1;
        load_start = noise;
        nvm_valid  = noise;
        nvm_bit    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        load_start = 1'b0;
        nvm_valid  = 1'b0;
        chk("rst_key",   key_out,   DECOY);
        chk("rst_valid", key_valid, 0);
        chk("rst_err",   key_err,   0);
        chk("rst_ready", nvm_ready, 0);
        chk("rst_busy",  busy,      0);
        chk("rst_state", dbg_state, IDLE_ENC);
        @(posedge clk);
        #1;
        chk("post_rst_state", dbg_state, IDLE_ENC);
        chk("post_rst_ready", nvm_ready, 0);
    endtask

    // Drive one complete frame from load_start through the verdict.
    // Called and returns #1 after a rising edge.
    task automatic run_frame(input logic [15:0] key, input logic pbit, input int stall,
                             input bit poke, input logic [15:0] e_out,
                             input logic e_valid, input logic e_err);
        logic [16:0] frame;
        logic [15:0] e_key;
        int idx;
        int edges;
        int guard;
        logic v;
        frame = {pbit, key};
        exp_q.push_back(e_out);

        load_start = 1'b1;
        nvm_valid  = 1'b0;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        edges = 1;
        chk("e0_ready", nvm_ready, 1);
        chk("e0_busy",  busy,      1);
        chk("e0_key",   key_out,   DECOY);
        chk("e0_valid", key_valid, 0);
        chk("e0_err",   key_err,   0);

        idx = 0;
        guard = 0;
        while (idx < 17 && guard < 400) begin
            case (stall)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            nvm_valid  = v;
            nvm_bit    = frame[idx[4:0]];
            load_start = poke && ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            edges++;
            guard++;
            if (v) idx++;
            load_start = 1'b0;
            chk("shift_key",   key_out,   DECOY);
            chk("shift_valid", key_valid, 0);
            chk("shift_ready", nvm_ready, (idx < 17) ? 1 : 0);
            chk("shift_busy",  busy,      1);
        end
        if (idx < 17) chk("frame_timeout", idx, 17);

        // CHECK cycle: offer a stray extra bit, which must not be taken.
        nvm_valid = 1'b1;
        nvm_bit   = ~pbit;
        chk("check_ready", nvm_ready, 0);
        chk("check_busy",  busy,      1);
        chk("check_key",   key_out,   DECOY);
        @(posedge clk);
        #1;
        edges++;
        nvm_valid = 1'b0;
        e_key = exp_q.pop_front();
        chk("result_key",   key_out,   e_key);
        chk("result_valid", key_valid, e_valid);
        chk("result_err",   key_err,   e_err);
        chk("result_busy",  busy,      0);
        chk("result_ready", nvm_ready, 0);
        if (stall == 0) chk("latency_edges", edges, 19);

        // Result must hold (including a sticky error) while idle inputs wiggle.
        for (int k = 0; k < 3; k++) begin
            nvm_valid = 1'($urandom_range(0, 1));
            nvm_bit   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("hold_key",   key_out,   e_key);
            chk("hold_valid", key_valid, e_valid);
            chk("hold_err",   key_err,   e_err);
        end
        nvm_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] rkey;
        logic        rpar;
        bit          ok;
        int          rstall;

        rst = 1'b0; load_start = 1'b0; nvm_valid = 1'b0; nvm_bit = 1'b0;

        vecs[0] = '{16'h1234, 1'b1, 0, 1'b0, 16'h1234, 1'b1, 1'b0}; // good key, latency
        vecs[1] = '{16'h1234, 1'b0, 0, 1'b0, DECOY,    1'b0, 1'b1}; // bad parity
        vecs[2] = '{16'hBEEF, 1'b1, 1, 1'b1, 16'hBEEF, 1'b1, 1'b0}; // stalls + ignored start
        vecs[3] = '{16'h1234, 1'b1, 0, 1'b0, 16'h1234, 1'b1, 1'b0}; // commit before reload
        vecs[4] = '{16'h00FF, 1'b0, 0, 1'b0, 16'h00FF, 1'b1, 1'b0}; // reload from DONE
        vecs[5] = '{16'hFFFF, 1'b0, 0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 1'b1, 2, 1'b0, DECOY,    1'b0, 1'b1};
        vecs[7] = '{16'h0001, 1'b1, 0, 1'b0, 16'h0001, 1'b1, 1'b0};

        do_reset(1'b0);

        // Reset mid-frame: 8 bits accepted, then reset with start/valid noise.
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nvm_valid = 1'b1;
            nvm_bit   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        do_reset(1'b1);
        run_frame(16'h1234, 1'b1, 0, 1'b0, 16'h1234, 1'b1, 1'b0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].key, vecs[i].pbit, vecs[i].stall, vecs[i].poke,
                      vecs[i].exp_out, vecs[i].exp_valid, vecs[i].exp_err);
        end

        // Randomized frames against the parity model.
        for (int i = 0; i < 40; i++) begin
            rkey   = 16'($urandom);
            rpar   = 1'($urandom_range(0, 1));
            rstall = $urandom_range(0, 2);
            ok     = (($countones(rkey) + int'(rpar)) % 2) == 0;
            run_frame(rkey, rpar, rstall, 1'($urandom_range(0, 1)),
                      ok ? rkey : DECOY, ok, !ok);
        end

        // Reset while a key is committed must hide it again.
        run_frame(16'hC0DE, 1'(($countones(16'hC0DE)) % 2), 0, 1'b0, 16'hC0DE, 1'b1, 1'b0);
        do_reset(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
